// File: rtl/ethernet_rx_dispatch.sv
// Ethernet receive frame dispatcher: parses the 14-byte header, filters on destination MAC,
// and steers IPv4/ARP payloads through a shared tagged FIFO with truncate-on-overflow.
module ethernet_rx_dispatch #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [47:0] DEFAULT_MAC = 48'h020000000001
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_last,
  input  logic        i_cfg_mac_we,
  input  logic [47:0] i_cfg_mac,
  input  logic        i_cfg_promisc,
  output logic [7:0]  o_ip_data,
  output logic        o_ip_valid,
  input  logic        i_ip_ready,
  output logic        o_ip_last,
  output logic        o_ip_err,
  output logic [7:0]  o_arp_data,
  output logic        o_arp_valid,
  input  logic        i_arp_ready,
  output logic        o_arp_last,
  output logic        o_arp_err,
  output logic [15:0] o_frames_ok,
  output logic [15:0] o_frames_dropped,
  output logic        o_overflow
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE   = (AW + 1)'(1);
  localparam logic [AW:0] ZERO  = (AW + 1)'(0);

  typedef enum logic [2:0] {
    S_IDLE, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_DISCARD
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_idx, w_idx, w_idx_n;
  logic [47:0] r_mac;
  logic        r_mac_ok, w_mac_ok_n, r_bc_ok, w_bc_ok_n;
  logic        r_accept, w_accept_n, r_route, w_route_n;
  logic [7:0]  r_type_hi, w_type_hi_n;
  logic [15:0] r_ok, r_dropped;
  logic        r_overflow;
  logic        w_ok_inc, w_drop_inc, w_ovf;

  // FIFO entry layout: {route(1=ARP), err, last, data[7:0]}
  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_free;
  logic          w_push, w_pop, w_empty;
  logic [10:0]   w_push_word, w_head;

  logic [5:0]  w_shift;
  logic [47:0] w_mac_sh;
  logic        w_mac_all, w_bc_all;
  logic [15:0] w_type;

  assign w_idx     = (r_state == S_IDLE) ? 4'd0 : r_idx;
  assign w_shift   = 6'd40 - {w_idx[2:0], 3'b000};
  assign w_mac_sh  = r_mac >> w_shift;
  assign w_mac_all = (i_rx_data == w_mac_sh[7:0]) && ((w_idx == 4'd0) || r_mac_ok);
  assign w_bc_all  = (i_rx_data == 8'hFF) && ((w_idx == 4'd0) || r_bc_ok);
  assign w_type    = {r_type_hi, i_rx_data};
  assign w_free    = DEPTH - r_count;

  // Header parse, filtering, FIFO push decision and counter events
  always_comb begin
    w_next      = r_state;
    w_idx_n     = r_idx;
    w_mac_ok_n  = r_mac_ok;
    w_bc_ok_n   = r_bc_ok;
    w_accept_n  = r_accept;
    w_type_hi_n = r_type_hi;
    w_route_n   = r_route;
    w_push      = 1'b0;
    w_push_word = 11'h000;
    w_ok_inc    = 1'b0;
    w_drop_inc  = 1'b0;
    w_ovf       = 1'b0;
    if (i_rx_valid) begin
      case (r_state)
        S_IDLE, S_DST, S_SRC, S_TYPE: begin
          w_idx_n = w_idx + 4'd1;
          if (w_idx < 4'd6) begin
            w_mac_ok_n = w_mac_all;
            w_bc_ok_n  = w_bc_all;
          end else begin
            w_mac_ok_n = r_mac_ok;
          end
          if (w_idx == 4'd5) begin
            w_accept_n = w_mac_all || w_bc_all || i_cfg_promisc;
          end else begin
            w_accept_n = r_accept;
          end
          if (w_idx == 4'd12) begin
            w_type_hi_n = i_rx_data;
          end else begin
            w_type_hi_n = r_type_hi;
          end
          if (i_rx_last) begin
            w_drop_inc = 1'b1;
            w_next     = S_IDLE;
          end else if (w_idx == 4'd13) begin
            if (r_accept && (w_type == 16'h0800)) begin
              w_route_n = 1'b0;
              w_next    = S_PAYLOAD;
            end else if (r_accept && (w_type == 16'h0806)) begin
              w_route_n = 1'b1;
              w_next    = S_PAYLOAD;
            end else begin
              w_drop_inc = 1'b1;
              w_next     = S_DISCARD;
            end
          end else if (w_idx < 4'd5) begin
            w_next = S_DST;
          end else if (w_idx < 4'd11) begin
            w_next = S_SRC;
          end else begin
            w_next = S_TYPE;
          end
        end
        S_PAYLOAD: begin
          if ((w_free > ONE) || (i_rx_last && (w_free != ZERO))) begin
            w_push      = 1'b1;
            w_push_word = {r_route, 1'b0, i_rx_last, i_rx_data};
            if (i_rx_last) begin
              w_ok_inc = 1'b1;
              w_next   = S_IDLE;
            end else begin
              w_next = S_PAYLOAD;
            end
          end else if (w_free == ONE) begin
            // Last free slot: close the frame with an error marker instead of stalling
            w_push      = 1'b1;
            w_push_word = {r_route, 1'b1, 1'b1, i_rx_data};
            w_ovf       = 1'b1;
            w_drop_inc  = 1'b1;
            w_next      = S_DISCARD;
          end else begin
            // FIFO still full from an earlier frame: nothing of this frame is stored
            w_ovf      = 1'b1;
            w_drop_inc = 1'b1;
            w_next     = i_rx_last ? S_IDLE : S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (i_rx_last) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_DISCARD;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end else begin
      w_next = r_state;
    end
  end

  assign w_empty     = (r_count == ZERO);
  assign w_head      = r_mem[r_rd_ptr];
  assign o_ip_valid  = !w_empty && !w_head[10];
  assign o_arp_valid = !w_empty && w_head[10];
  assign o_ip_data   = w_head[7:0];
  assign o_arp_data  = w_head[7:0];
  assign o_ip_last   = w_head[8];
  assign o_arp_last  = w_head[8];
  assign o_ip_err    = w_head[9];
  assign o_arp_err   = w_head[9];
  assign w_pop       = (o_ip_valid && i_ip_ready) || (o_arp_valid && i_arp_ready);

  assign o_frames_ok      = r_ok;
  assign o_frames_dropped = r_dropped;
  assign o_overflow       = r_overflow;

  // Parser state, MAC register, counters and FIFO pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      r_mac      <= DEFAULT_MAC;
      r_mac_ok   <= 1'b0;
      r_bc_ok    <= 1'b0;
      r_accept   <= 1'b0;
      r_route    <= 1'b0;
      r_type_hi  <= 8'h00;
      r_ok       <= 16'h0000;
      r_dropped  <= 16'h0000;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= ZERO;
    end else begin
      r_state    <= w_next;
      r_idx      <= w_idx_n;
      r_mac_ok   <= w_mac_ok_n;
      r_bc_ok    <= w_bc_ok_n;
      r_accept   <= w_accept_n;
      r_route    <= w_route_n;
      r_type_hi  <= w_type_hi_n;
      r_overflow <= w_ovf;
      if (i_cfg_mac_we) r_mac <= i_cfg_mac;
      if (w_ok_inc && (r_ok != 16'hFFFF)) r_ok <= r_ok + 16'd1;
      if (w_drop_inc && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents need no reset since r_count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

endmodule

// File: doc/ethernet_rx_dispatch.md
Name: ethernet_rx_dispatch

Overview:
- Frame-level controller downstream of the Ethernet receive datapath.
- Consumes the received byte stream and parses the 14-byte header: destination MAC, source MAC, ethertype.
- Filters on destination MAC and steers each payload to the IPv4 consumer or the ARP consumer through a shared tagged FIFO; all other frames are discarded and counted.
- The receive side cannot be stalled, so buffer overflow truncates the frame rather than back-pressuring.

Parameters:
- FIFO_DEPTH, 16, payload FIFO entries; power of 2, >= 4.
- DEFAULT_MAC, 48'h020000000001, value loaded into the internal MAC register at reset.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  i_rx_data valid this cycle; no back-pressure
- i_rx_last  in  1  qualifies the final byte of a frame; meaningful only with i_rx_valid
- i_cfg_mac_we  in  1  load i_cfg_mac into the MAC register
- i_cfg_mac  in  48  station MAC; bits [47:40] are the first byte on the wire
- i_cfg_promisc  in  1  accept any destination MAC
- o_ip_data  out  8  IPv4 payload byte
- o_ip_valid  out  1
- i_ip_ready  in  1
- o_ip_last  out  1  final byte of frame
- o_ip_err  out  1  frame truncated; valid with o_ip_last
- o_arp_data, o_arp_valid, i_arp_ready, o_arp_last, o_arp_err  same widths and meaning, ARP channel
- o_frames_ok  out  16  frames fully delivered, saturating
- o_frames_dropped  out  16  frames filtered, runt or truncated, saturating
- o_overflow  out  1  one-cycle pulse on truncation

Behaviour:
- Reset: state IDLE, FIFO empty, MAC register = DEFAULT_MAC, counters 0, all valid outputs 0, o_overflow 0.
- i_cfg_mac_we takes effect next cycle. If it is written mid-header, the comparison of later bytes uses the new value.
- States:
  - IDLE: first valid byte goes to DST with byte index 0.
  - DST: indices 0-5.
  - SRC: indices 6-11.
  - TYPE: indices 12-13.
  - PAYLOAD.
  - DISCARD.
- Cycles with i_rx_valid low change nothing.
- Byte counter: 4 bits, increments per valid byte in DST/SRC/TYPE.
- MAC match: per byte, compare byte k to MAC register bits [47-8k -: 8], and separately to 8'hFF.
  - Accept if all six bytes match the MAC, or all six are FF, or i_cfg_promisc is sampled high at byte 5.
- Ethertype: byte 12 is the high byte. At byte 13:
  - accepted and 16'h0800 -> route IP, go to PAYLOAD;
  - accepted and 16'h0806 -> route ARP, go to PAYLOAD;
  - otherwise -> DISCARD and increment o_frames_dropped.
- Runt: i_rx_last on any byte with index 0-13 -> increment o_frames_dropped, go to IDLE. This includes byte 13 (zero payload); no FIFO write occurs.
- DISCARD: consume bytes; on i_rx_last go to IDLE. No further counter change.
- PAYLOAD, each valid byte pushes {route, err, last, data}:
  - If free slots > 1, or the byte carries i_rx_last: push {route, 0, i_rx_last, data}.
    - On i_rx_last: increment o_frames_ok, go to IDLE.
  - If exactly 1 free slot and the byte is not last: push {route, 1, 1, data}, pulse o_overflow, increment o_frames_dropped, go to DISCARD. If that byte also carried i_rx_last, the frame counts as ok and is not truncated.
  - The FIFO never fully overflows; no byte is written to a full FIFO.
- Output: head entry route selects the channel.
  - o_ip_valid = !empty && head.route == IP; o_arp_valid likewise.
  - The other channel's valid is 0.
  - Data, last and err come from the head entry.
  - Pop on valid && ready of the selected channel.
  - The ready of the unselected channel is ignored.
  - Head-of-line blocking across channels is intended.
- Latency: a byte pushed in cycle N is visible at the output in cycle N+1.
- Simultaneous push and pop leaves the count unchanged. Pop of the last entry with a simultaneous push gives valid next cycle.
- Counters stop at 16'hFFFF.
- Reset mid-frame:
  - FIFO contents are lost; no partial frame is presented after reset.
  - The state returns to IDLE, so the next valid byte is treated as destination byte 0.
  - The upstream block resets alongside this block.

Test Plan:
1. MAC register = 02:00:00:00:00:01; frame of that dst, any src, type 08 00, 20-byte payload 0x00..0x13, i_ip_ready=1 -> o_ip emits 0x00..0x13 with o_ip_last on 0x13, o_ip_err=0, o_frames_ok=1, o_arp_valid never high.
2. Broadcast dst FF×6, type 08 06, 28-byte payload -> delivered on ARP channel. Same frame with type 86 DD -> nothing output, o_frames_dropped=1.
3. Dst 02:00:00:00:00:02 with promisc=0 -> dropped. Same frame with promisc=1 -> delivered on IP.
4. FIFO_DEPTH=16, i_ip_ready=0, 40-byte IP payload -> 16 entries, 16th has last=1 and err=1, o_overflow pulses once, dropped=1, ok=0. Then ready=1 -> 16 bytes drained, bytes 16-39 absent.
5. 10-byte frame (last at index 9) -> dropped=1, no output. Immediately following valid IP frame -> delivered intact.
6. IP frame A (5 bytes) then ARP frame B back-to-back, i_ip_ready=0 and i_arp_ready=1 -> B stalls behind A. Raise i_ip_ready -> A delivered, then B. Finally i_rst mid-payload -> outputs invalid and counters 0 next cycle.
